fsm_monitor: RTL
================

FSM_MONITOR -- requirements
Module: fsm_monitor

Interface
REQ-001 Parameter: NUM_STATES, 9, number of states in the observed ring FSM; legal encodings 0..NUM_STATES-1.
REQ-002 Parameter: CNT_W, 8, width of all counters.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 valid  input  1  sample qualifier; the monitor ignores i, a and y when valid=0.
REQ-006 i  input  NUM_STATES  per-state advance conditions; bit k corresponds to state k.
REQ-007 a  input  4  current state of the observed FSM.
REQ-008 y  input  4  next state produced by the observed FSM.
REQ-009 clear  input  1  synchronous clear of all results; returns the monitor to IDLE.
REQ-010 error  output  1  sticky; set on the first detected violation.
REQ-011 err_count  output  CNT_W  number of violations; saturates at all-ones.
REQ-012 first_a, first_y  output  4 each  a and y captured at the first violation.
REQ-013 first_cycle  output  CNT_W  value of cycles at the first violation.
REQ-014 visited  output  NUM_STATES  bit k set once a==k has been sampled in TRACK or FAIL.
REQ-015 wraps  output  CNT_W  count of legal NUM_STATES-1 -> 0 transitions; saturates.
REQ-016 cycles  output  CNT_W  count of valid samples since leaving IDLE; saturates.
REQ-017 all_visited  output  1  registered AND of visited.

Function
REQ-018 The reference next state is exp = (i[a] ? (a==NUM_STATES-1 ? 0 : a+1) : a).
REQ-019 A sample is a violation if any of the following holds:
- a >= NUM_STATES;
- y != exp;
- a != y of the previous valid sample (continuity), when a previous valid sample exists in TRACK or FAIL.
REQ-020 Monitor FSM has three states: IDLE, TRACK and FAIL.
REQ-021 IDLE: on valid=1 with a==0, go to TRACK and process this sample as the first sample; all other samples are ignored.
REQ-022 TRACK: on valid=1 with a violation, go to FAIL; otherwise remain in TRACK.
REQ-023 FAIL: state is terminal until clear or reset; samples continue to update err_count, visited, wraps and cycles.
REQ-024 On every processed sample, cycles increments by 1 (saturating).
REQ-025 On every violating sample, err_count increments by 1 (saturating).
REQ-026 first_a, first_y and first_cycle load only on the violation that sets error; they hold thereafter.
REQ-027 first_cycle takes the pre-increment value of cycles.
REQ-028 All outputs are registered and reflect a sample one cycle after the clock edge that samples it.
REQ-029 A continuity violation does not suppress the check of the same sample against exp; a sample that violates both rules increments err_count by 1 only.
REQ-030 If a >= NUM_STATES, the monitor does not index i, does not update visited, and does not count a wrap.
REQ-031 clear=1 has priority over valid in the same cycle: all outputs go to 0 and the monitor goes to IDLE.
REQ-032 Saturation: a counter at all-ones holds its value; it never wraps to 0.

Reset
REQ-033 While reset=0, the monitor is in IDLE and all outputs are 0, independent of clock.
REQ-034 Reset deassertion mid-run discards all previous history, including the continuity reference.

Structure
REQ-035 Package fsm_pkg holds NUM_STATES, the state width (4) and the monitor state enum (IDLE, TRACK, FAIL).
REQ-036 Sub-module fsm_ref_next is the combinational reference next-state function of REQ-018 and is reusable by other benches.

Verification
REQ-037 Scenario "legal run": i=all ones, legal ring FSM, 20 valid cycles from a=0.
- Required response: error=0, cycles=20, wraps=2, all_visited=1.
REQ-038 Scenario "wrong transition": i[3]=0, and the stimulus drives a=3, y=4 at cycles=3.
- Required response: error=1, first_a=3, first_y=4, first_cycle=3, err_count=1, state FAIL.
REQ-039 Scenario "continuity": previous y=5, then next sample drives a=6 with legal y=7.
- Required response: err_count increments by exactly 1.
REQ-040 Scenario "illegal encoding": drive a=12.
- Required response: violation counted; visited and wraps unchanged.
REQ-041 Scenario "saturation and clear": 300 legal samples, then clear together with valid.
- After the 300 samples: cycles=255.
- After clear: all outputs 0 and state IDLE.
REQ-042 Scenario "async reset": drive reset=0 between clock edges while in FAIL.
- Required response: outputs 0 immediately.
- After reset deasserts, samples with a!=0 are ignored until a==0.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the ring-FSM monitor: observed FSM geometry and monitor states.
package fsm_pkg;
    localparam int NUM_STATES = 9;
    localparam int STATE_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAIL  = 2'd2
    } mon_state_t;
endpackage

// File: rtl/fsm_monitor_if.sv
// Sample bus into the monitor and the registered results coming back out.
interface fsm_monitor_if #(
    parameter int NUM_STATES = fsm_pkg::NUM_STATES,
    parameter int CNT_W      = 8
);
    import fsm_pkg::*;

    logic                  valid;
    logic                  clear;
    logic [NUM_STATES-1:0] i;
    logic [STATE_W-1:0]    a;
    logic [STATE_W-1:0]    y;

    logic                  error;
    logic [CNT_W-1:0]      err_count;
    logic [STATE_W-1:0]    first_a;
    logic [STATE_W-1:0]    first_y;
    logic [CNT_W-1:0]      first_cycle;
    logic [NUM_STATES-1:0] visited;
    logic [CNT_W-1:0]      wraps;
    logic [CNT_W-1:0]      cycles;
    logic                  all_visited;

    modport master (
        output valid, clear, i, a, y,
        input  error, err_count, first_a, first_y, first_cycle,
               visited, wraps, cycles, all_visited
    );

    modport slave (
        input  valid, clear, i, a, y,
        output error, err_count, first_a, first_y, first_cycle,
               visited, wraps, cycles, all_visited
    );
endinterface

// File: rtl/fsm_ref_next.sv
// Reference next state of the observed ring FSM; i is never indexed with an illegal encoding.
module fsm_ref_next
    import fsm_pkg::*;
#(
    parameter int NUM_STATES = fsm_pkg::NUM_STATES
) (
    input  logic [NUM_STATES-1:0] i,
    input  logic [STATE_W-1:0]    a,
    output logic [STATE_W-1:0]    exp_next,
    output logic                  legal
);
    localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STATES - 1);

    always_comb begin
        legal    = (a <= LAST);
        exp_next = a;
        if (legal && i[a]) begin
            exp_next = (a == LAST) ? '0 : a + 1'b1;
        end
    end
endmodule

// File: rtl/fsm_monitor.sv
// Checks an observed ring FSM sample by sample and records the first violation and coverage.
module fsm_monitor
    import fsm_pkg::*;
#(
    parameter int NUM_STATES = fsm_pkg::NUM_STATES,
    parameter int CNT_W      = 8
) (
    input logic         clock,
    input logic         reset,
    fsm_monitor_if.slave mon
);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [STATE_W-1:0] LAST    = STATE_W'(NUM_STATES - 1);

    mon_state_t            state;
    mon_state_t            state_nxt;
    logic [STATE_W-1:0]    exp_next;
    logic                  a_legal;
    logic [STATE_W-1:0]    prev_y;
    logic                  take;
    logic                  viol;
    logic                  wrap;
    logic [NUM_STATES-1:0] visited_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    fsm_ref_next #(.NUM_STATES(NUM_STATES)) u_ref (
        .i        (mon.i),
        .a        (mon.a),
        .exp_next (exp_next),
        .legal    (a_legal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mon.clear) begin
            state_nxt = IDLE;
        end else if (take) begin
            case (state)
                IDLE:    state_nxt = viol ? FAIL : TRACK;
                TRACK:   state_nxt = viol ? FAIL : TRACK;
                FAIL:    state_nxt = FAIL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outside IDLE a previous sample always exists, so continuity is checked whenever not IDLE.
    always_comb begin
        take = mon.valid && !mon.clear && ((state != IDLE) || (mon.a == '0));
        viol = !a_legal || (mon.y != exp_next) || ((state != IDLE) && (mon.a != prev_y));
        wrap = a_legal && (mon.a == LAST) && (exp_next == '0) && (mon.y == '0);
        visited_nxt = mon.visited;
        if (take && a_legal) visited_nxt[mon.a] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (take) prev_y <= mon.y;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset || mon.clear) begin
            mon.error       <= 1'b0;
            mon.err_count   <= '0;
            mon.first_a     <= '0;
            mon.first_y     <= '0;
            mon.first_cycle <= '0;
            mon.visited     <= '0;
            mon.wraps       <= '0;
            mon.cycles      <= '0;
            mon.all_visited <= 1'b0;
        end else if (take) begin
            mon.cycles      <= sat_inc(mon.cycles);
            mon.visited     <= visited_nxt;
            mon.all_visited <= &visited_nxt;
            if (wrap) mon.wraps <= sat_inc(mon.wraps);
            if (viol) begin
                mon.err_count <= sat_inc(mon.err_count);
                if (!mon.error) begin
                    mon.error       <= 1'b1;
                    mon.first_a     <= mon.a;
                    mon.first_y     <= mon.y;
                    mon.first_cycle <= mon.cycles;
                end
            end
        end
    end
endmodule
